rand_word_packer: RTL and testbench

//  Parametrised successor of the 8-bit random-bit shifter. Packs coherent-sampler

---
 rtl/rand_word_packer_if.sv | 31 +++
 rtl/rand_word_packer.sv | 109 ++++++++++
 tb/tb_rand_word_packer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rand_word_packer_if.sv
// Bit-in / word-out bus of rand_word_packer.
//   randBit, CSReq : sampler side (raw bit plus "bit stable" strobe)
//   randWord, randValid, randReady : word handshake toward readout
//   fillLevel, overflow, dropCnt   : FIFO status
// master = sampler/readout side, slave = packer side.
interface rand_word_packer_if #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic                  randBit;
  logic                  CSReq;
  logic [WORD_W-1:0]     randWord;
  logic                  randValid;
  logic                  randReady;
  logic [LVL_W-1:0]      fillLevel;
  logic                  overflow;
  logic [DROP_CNT_W-1:0] dropCnt;

  modport master (
    output randBit, CSReq, randReady,
    input  randWord, randValid, fillLevel, overflow, dropCnt
  );

  modport slave (
    input  randBit, CSReq, randReady,
    output randWord, randValid, fillLevel, overflow, dropCnt
  );
endinterface

// File: rtl/rand_word_packer.sv
// rand_word_packer: packs sampled random bits MSB-first into WORD_W-bit words,
// queues them in a FIFO_DEPTH-entry FIFO and presents the head word on a
// valid/ready handshake. Words arriving while the FIFO is full (and not being
// popped that cycle) are dropped, counted in a saturating counter and flagged.
// Ports:
//   clk  : system clock
//   rst  : synchronous, active-high reset
//   bus  : rand_word_packer_if.slave (randBit/CSReq in, word handshake out,
//          fillLevel/overflow/dropCnt status out)
// Optional feature: define VON_NEUMANN_EN to place a von Neumann debiaser
// ahead of the shifter (pairs 01 -> 0, 10 -> 1, 00/11 discarded).
module rand_word_packer #(
  parameter int WORD_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 16
) (
  input logic             clk,
  input logic             rst,
  rand_word_packer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [WORD_W-2:0] shift_reg;
  logic [CW-1:0]     bit_cnt;
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level;
  logic              ovf;
  logic [DROP_CNT_W-1:0] drop_cnt;

  logic              acc_vld, acc_bit;
  logic [WORD_W-1:0] word_in;
  logic              push, pop, full, do_push, drop;

  // ---------------- accepted-bit source ----------------
`ifdef VON_NEUMANN_EN
  logic pair_second;  // 0: next CSReq is first of a pair
  logic pair_bit;

  // Second bit of a differing pair yields the first bit (01 -> 0, 10 -> 1).
  assign acc_vld = bus.CSReq && pair_second && (bus.randBit != pair_bit);
  assign acc_bit = pair_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_second <= 1'b0;
      pair_bit    <= 1'b0;
    end else if (bus.CSReq) begin
      pair_second <= ~pair_second;
      if (!pair_second) pair_bit <= bus.randBit;
    end
  end
`else
  assign acc_vld = bus.CSReq;
  assign acc_bit = bus.randBit;
`endif

  // ---------------- packing / FIFO control ----------------
  assign word_in = {shift_reg, acc_bit};
  assign push    = acc_vld && (bit_cnt == LAST_BIT);
  assign pop     = bus.randValid && bus.randReady;
  assign full    = (level == FULL_LVL);
  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign do_push = push && (!full || pop) && !rst;
  assign drop    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      ovf       <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      if (acc_vld) begin
        shift_reg <= word_in[WORD_W-2:0];
        bit_cnt   <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + CW'(1);
      end
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
      if (drop) begin
        ovf <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_CNT_W'(1);
      end
    end
  end

  // Storage carries no reset; the output mux hides stale contents when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= word_in;
  end

  assign bus.randValid = (level != '0);
  assign bus.randWord  = bus.randValid ? mem[rd_ptr] : '0;
  assign bus.fillLevel = level;
  assign bus.overflow  = ovf;
  assign bus.dropCnt   = drop_cnt;
endmodule

// File: tb/tb_rand_word_packer.sv
module tb_rand_word_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rand_word_packer_if #(.WORD_W(8),  .FIFO_DEPTH(4), .DROP_CNT_W(16)) b8();
  rand_word_packer_if #(.WORD_W(16), .FIFO_DEPTH(4), .DROP_CNT_W(16)) b16();

  rand_word_packer #(.WORD_W(8),  .FIFO_DEPTH(4), .DROP_CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(b8));
  rand_word_packer #(.WORD_W(16), .FIFO_DEPTH(4), .DROP_CNT_W(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // ---------------- scoreboards + monitors ----------------
  logic [7:0]  q8[$];
  logic [15:0] q16[$];
  logic        held8 = 1'b0;
  logic [7:0]  hw8;
  int          pops16 = 0;

  always @(negedge clk) begin
    if (rst) held8 = 1'b0;
    else begin
      if (held8 && b8.randValid) chk("head_stable8", 64'(b8.randWord), 64'(hw8));
      if (b8.randValid && b8.randReady) begin
        if (q8.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_word8: got %0h expected none", b8.randWord);
        end else chk("word8", 64'(b8.randWord), 64'(q8.pop_front()));
      end
      held8 = b8.randValid && !b8.randReady;
      hw8   = b8.randWord;
    end
  end

  always @(negedge clk) begin
    if (!rst && b16.randValid && b16.randReady) begin
      pops16++;
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_word16: got %0h expected none", b16.randWord);
      end else chk("word16", 64'(b16.randWord), 64'(q16.pop_front()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; b8.CSReq = 1'b0; b16.CSReq = 1'b0;
    tick();
    rst = 1'b0;
    q8.delete(); q16.delete();
  endtask

  task automatic bit8(input logic b);
    b8.randBit = b; b8.CSReq = 1'b1;
    tick();
    b8.CSReq = 1'b0;
  endtask

  task automatic word8(input logic [7:0] w, input bit keep);
    if (keep) q8.push_back(w);
    for (int i = 7; i >= 0; i--) bit8(w[i]);
  endtask

  task automatic word16(input logic [15:0] w);
    q16.push_back(w);
    for (int i = 15; i >= 0; i--) begin
      b16.randBit = w[i]; b16.CSReq = 1'b1;
      tick();
      b16.CSReq = 1'b0;
    end
  endtask

  task automatic drain8();
    b8.randReady = 1'b1;
    for (int i = 0; i < 20 && b8.randValid; i++) tick();
    b8.randReady = 1'b0;
    chk("drain8_empty", 64'(b8.randValid), 64'(0));
    chk("queue8_empty", 64'(q8.size()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    b8.randBit = 1'b0; b8.CSReq = 1'b0; b8.randReady = 1'b0;
    b16.randBit = 1'b0; b16.CSReq = 1'b0; b16.randReady = 1'b0;
    tick();
    do_reset();

    // reset state
    chk("rst_valid",    64'(b8.randValid), 64'(0));
    chk("rst_fill",     64'(b8.fillLevel), 64'(0));
    chk("rst_overflow", 64'(b8.overflow),  64'(0));
    chk("rst_dropcnt",  64'(b8.dropCnt),   64'(0));
    chk("rst_word",     64'(b8.randWord),  64'(0));
    chk("rst_valid16",  64'(b16.randValid), 64'(0));

`ifdef VON_NEUMANN_EN
    // pairs 01,11,10,00,01 -> accepted 0,1,0 per group; first word 8'h49
    for (int g = 0; g < 4; g++) begin
      if (g == 2) q8.push_back(8'h49);
      bit8(1'b0); bit8(1'b1);
      bit8(1'b1); bit8(1'b1);
      bit8(1'b1); bit8(1'b0);
      bit8(1'b0); bit8(1'b0);
      bit8(1'b0); bit8(1'b1);
      if (g == 1) chk("vn_no_word_6bits", 64'(b8.randValid), 64'(0));
    end
    chk("vn_fill",  64'(b8.fillLevel), 64'(1));
    chk("vn_word",  64'(b8.randWord),  64'(8'h49));
    drain8();
`else
    // 1: bits 1,0,1,1,0,0,1,0 -> 8'hB2, valid the cycle after the 8th bit
    q8.push_back(8'hB2);
    bit8(1); bit8(0); bit8(1); bit8(1); bit8(0); bit8(0); bit8(1);
    chk("t1_not_valid_7bits", 64'(b8.randValid), 64'(0));
    bit8(0);
    chk("t1_valid", 64'(b8.randValid), 64'(1));
    chk("t1_word",  64'(b8.randWord),  64'(8'hB2));
    chk("t1_fill",  64'(b8.fillLevel), 64'(1));
    drain8();

    // 2: five words with randReady=0 -> fifth dropped
    do_reset();
    word8(8'h11, 1); word8(8'h22, 1); word8(8'h33, 1); word8(8'h44, 1);
    chk("t2_full_no_ovf", 64'(b8.overflow), 64'(0));
    word8(8'h55, 0);
    chk("t2_fill",     64'(b8.fillLevel), 64'(4));
    chk("t2_overflow", 64'(b8.overflow),  64'(1));
    chk("t2_dropcnt",  64'(b8.dropCnt),   64'(1));
    chk("t2_head",     64'(b8.randWord),  64'(8'h11));
    drain8();
    chk("t2_ovf_sticky", 64'(b8.overflow), 64'(1));

    // 3: full FIFO, pop coincides with completing bit -> no drop
    do_reset();
    word8(8'hA1, 1); word8(8'hA2, 1); word8(8'hA3, 1); word8(8'hA4, 1);
    q8.push_back(8'hA5);
    for (int i = 7; i >= 1; i--) bit8(8'hA5 >> i);
    b8.randReady = 1'b1;
    bit8(1'b1);
    b8.randReady = 1'b0;
    chk("t3_fill",     64'(b8.fillLevel), 64'(4));
    chk("t3_overflow", 64'(b8.overflow),  64'(0));
    chk("t3_dropcnt",  64'(b8.dropCnt),   64'(0));
    chk("t3_head",     64'(b8.randWord),  64'(8'hA2));
    drain8();

    // 4: partial word discarded by reset
    do_reset();
    bit8(1); bit8(1); bit8(1);
    do_reset();
    word8(8'h5A, 1);
    chk("t4_fill", 64'(b8.fillLevel), 64'(1));
    chk("t4_word", 64'(b8.randWord),  64'(8'h5A));
    drain8();

    // 5: WORD_W=16, randReady held high, 32 bits -> exactly two words
    do_reset();
    b16.randReady = 1'b1;
    word16(16'hC3A5);
    word16(16'h7E01);
    tick(); tick();
    chk("t5_words",     64'(pops16),         64'(2));
    chk("t5_queue",     64'(q16.size()),     64'(0));
    chk("t5_fill",      64'(b16.fillLevel),  64'(0));
    chk("t5_overflow",  64'(b16.overflow),   64'(0));
    b16.randReady = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
